note_highway_judge: RTL and testbench

//  Downstream consumer of the song-note ROM. On each beat tick it samples the 5-bit note

---
 rtl/note_highway_judge.sv | 157 +++++++++++++++
 tb/tb_note_highway_judge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_highway_judge.sv
// note_highway_judge: scrolling note highway with strum judging, score and combo.
// Beat ticks shift song-ROM note words through a ROWS-deep highway; strums are judged
// against the bottom (hit) row. Optional macro STRUM_HOLDOFF_EN ignores strums for
// HOLDOFF_CYC cycles after each judged strum.
module note_highway_judge #(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned COMBO_W     = 8,
    parameter int unsigned HOLDOFF_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                beat,
    input  logic [4:0]          note_in,
    input  logic                song_end,
    input  logic [4:0]          buttons,
    input  logic                strum,
    output logic [ROWS*5-1:0]   highway,
    output logic [SCORE_W-1:0]  score,
    output logic [COMBO_W-1:0]  combo,
    output logic                hit,
    output logic                miss,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                   state_q;
    logic [ROWS-1:0][4:0]     rows_q;
    logic [SCORE_W-1:0]       score_q;
    logic [COMBO_W-1:0]       combo_q;
    logic                     hit_q;
    logic                     miss_q;

    logic                     active;
    logic                     start_accept;
    logic                     strum_free;
    logic                     strum_judged;
    logic                     hit_now;
    logic                     drop_now;
    logic                     miss_now;
    logic [4:0]               hit_row;
    logic [2:0]               mult;
    logic [SCORE_W:0]         score_sum;
    logic [SCORE_W-1:0]       score_sat;
    logic [COMBO_W-1:0]       combo_inc;
    logic [ROWS-1:0][4:0]     rows_judged;
    logic [ROWS-1:0][4:0]     rows_shift;

`ifdef STRUM_HOLDOFF_EN
    localparam int unsigned HoldW = $clog2(HOLDOFF_CYC + 1);
    logic [HoldW-1:0] holdoff_q;

    assign strum_free = (holdoff_q == '0);

    // Holdoff counter: reloads on each judged strum, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff_q <= '0;
        end else if (start_accept) begin
            holdoff_q <= '0;
        end else if (strum_judged) begin
            holdoff_q <= HoldW'(HOLDOFF_CYC);
        end else if (holdoff_q != '0) begin
            holdoff_q <= holdoff_q - 1'b1;
        end
    end
`else
    assign strum_free = 1'b1;
`endif

    // Judge strums against the pre-shift hit row and build the next highway contents.
    always_comb begin
        active       = (state_q == StRun) || (state_q == StFlush);
        start_accept = start && ((state_q == StIdle) || (state_q == StDone));
        hit_row      = rows_q[ROWS-1];
        strum_judged = active && strum && strum_free;
        hit_now      = strum_judged && (hit_row != 5'd0) && (buttons == hit_row);
        // A row hit this cycle has already been cleared, so it cannot also drop.
        drop_now     = active && beat && (hit_row != 5'd0) && !hit_now;
        miss_now     = (strum_judged && !hit_now) || drop_now;

        if (combo_q >= COMBO_W'(24)) begin
            mult = 3'd4;
        end else begin
            mult = 3'(combo_q >> 3) + 3'd1;
        end
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(mult);
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        combo_inc = (&combo_q) ? combo_q : combo_q + 1'b1;

        rows_judged = rows_q;
        if (hit_now) begin
            rows_judged[ROWS-1] = 5'd0;
        end
        rows_shift    = rows_judged << 5;
        rows_shift[0] = (state_q == StRun) ? note_in : 5'd0;
    end

    // Main FSM with registered score, combo and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rows_q  <= '0;
            score_q <= '0;
            combo_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        rows_q  <= '0;
                        score_q <= '0;
                        combo_q <= '0;
                    end
                end
                StRun, StFlush: begin
                    if (hit_now) begin
                        hit_q   <= 1'b1;
                        score_q <= score_sat;
                        combo_q <= combo_inc;
                    end
                    if (miss_now) begin
                        miss_q  <= 1'b1;
                        combo_q <= '0;
                    end
                    if (beat) begin
                        rows_q <= rows_shift;
                        if (state_q == StRun && song_end) begin
                            state_q <= StFlush;
                        end else if (state_q == StFlush && rows_shift == '0) begin
                            state_q <= StDone;
                        end
                    end else begin
                        rows_q <= rows_judged;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign highway = rows_q;
    assign score   = score_q;
    assign combo   = combo_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign busy    = (state_q == StRun) || (state_q == StFlush);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_note_highway_judge.sv
// Bench for note_highway_judge: directed steps, a behavioural model feeding a
// scoreboard queue, and immediate-assertion checks.
module tb_note_highway_judge;

    localparam int unsigned ROWS = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              beat = 1'b0;
    logic [4:0]        note_in = '0;
    logic              song_end = 1'b0;
    logic [4:0]        buttons = '0;
    logic              strum = 1'b0;
    logic [ROWS*5-1:0] highway;
    logic [15:0]       score;
    logic [7:0]        combo;
    logic              hit;
    logic              miss;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    note_highway_judge #(
        .ROWS(ROWS),
        .SCORE_W(16),
        .COMBO_W(8),
        .HOLDOFF_CYC(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .beat(beat),
        .note_in(note_in),
        .song_end(song_end),
        .buttons(buttons),
        .strum(strum),
        .highway(highway),
        .score(score),
        .combo(combo),
        .hit(hit),
        .miss(miss),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        hit;
        logic        miss;
        logic        busy;
        logic        done;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [39:0] hwy;
    } exp_t;

    exp_t sbq[$];

    // Reference model state: 0 idle, 1 run, 2 flush, 3 done.
    int              m_state = 0;
    logic [7:0][4:0] m_rows = '0;
    int              m_score = 0;
    int              m_combo = 0;
    int              m_hold = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_snapshot(input string tag, input logic h, input logic m);
        exp_t e;
        e.tag   = tag;
        e.hit   = h;
        e.miss  = m;
        e.busy  = (m_state == 1) || (m_state == 2);
        e.done  = (m_state == 3);
        e.score = 16'(m_score);
        e.combo = 8'(m_combo);
        e.hwy   = m_rows;
        return e;
    endfunction

    task automatic compare_front();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sbq.pop_front();
        chk({e.tag, ".hit"}, hit, e.hit);
        chk({e.tag, ".miss"}, miss, e.miss);
        chk({e.tag, ".busy"}, busy, e.busy);
        chk({e.tag, ".done"}, done, e.done);
        chk({e.tag, ".score"}, score, e.score);
        chk({e.tag, ".combo"}, combo, e.combo);
        chk({e.tag, ".highway"}, highway, e.hwy);
    endtask

    // Drive one cycle of stimulus, predict the outcome, then compare after the edge.
    task automatic step(input string tag, input logic st, input logic b, input logic s,
                        input logic [4:0] n, input logic [4:0] btn, input logic se);
        logic act, sok, match, start_acc, e_hit, e_miss, all_zero;
        int   mult;
        start = st; beat = b; strum = s; note_in = n; buttons = btn; song_end = se;
        e_hit = 1'b0;
        e_miss = 1'b0;
        act = (m_state == 1) || (m_state == 2);
        start_acc = st && ((m_state == 0) || (m_state == 3));
`ifdef STRUM_HOLDOFF_EN
        sok = act && s && (m_hold == 0);
`else
        sok = act && s;
`endif
        match = sok && (m_rows[7] != 5'd0) && (btn == m_rows[7]);
        if (match) begin
            e_hit = 1'b1;
            mult = 1 + m_combo / 8;
            if (mult > 4) mult = 4;
            m_score = (m_score + mult > 65535) ? 65535 : m_score + mult;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
            m_rows[7] = 5'd0;
        end else if (sok) begin
            e_miss = 1'b1;
            m_combo = 0;
        end
        if (start_acc) m_hold = 0;
        else if (sok) m_hold = 4;
        else if (m_hold > 0) m_hold = m_hold - 1;
        if (act && b) begin
            if (m_rows[7] != 5'd0) begin
                e_miss = 1'b1;
                m_combo = 0;
            end
            for (int k = 7; k > 0; k--) m_rows[k] = m_rows[k-1];
            m_rows[0] = (m_state == 1) ? n : 5'd0;
            all_zero = (m_rows == '0);
            if (m_state == 1 && se) m_state = 2;
            else if (m_state == 2 && all_zero) m_state = 3;
        end
        if (start_acc) begin
            m_state = 1;
            m_rows = '0;
            m_score = 0;
            m_combo = 0;
        end
        sbq.push_back(model_snapshot(tag, e_hit, e_miss));
        @(posedge clk);
        #1;
        start = 1'b0; beat = 1'b0; strum = 1'b0; song_end = 1'b0;
        compare_front();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    int pulses;
    int saved_score;
    int budget;

    initial begin
        // Reset state
        #12;
        sbq.push_back(model_snapshot("reset", 1'b0, 1'b0));
        compare_front();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Eight beats of a single-lane note fill the highway; the ninth drops one
        step("start", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) step("fill1", 1'b0, 1'b1, 1'b0, 5'b00001, 5'd0, 1'b0);
        chk("row7_after_8_beats", highway[39:35], 5'b00001);
        step("beat9_drop", 1'b0, 1'b1, 1'b0, 5'b00001, 5'd0, 1'b0);
        chk("beat9_miss", miss, 1'b1);
        chk("beat9_combo", combo, 8'd0);
        chk("beat9_row7", highway[39:35], 5'b00001);

        // Correct strum clears the hit row; next beat must not report a drop
        for (int i = 0; i < 8; i++) step("fill4", 1'b0, 1'b1, 1'b0, 5'b00100, 5'd0, 1'b0);
        step("strum_hit", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00100, 1'b0);
        chk("first_hit_score", score, 16'd1);
        chk("first_hit_combo", combo, 8'd1);
        chk("first_hit_row7", highway[39:35], 5'd0);
        step("beat_after_hit", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        chk("no_drop_after_hit", miss, 1'b0);

        // Beat and correct strum in the same cycle
        idle(4);
        step("beat_strum", 1'b0, 1'b1, 1'b1, 5'd0, 5'b00100, 1'b0);
        chk("beat_strum_hit", hit, 1'b1);
        chk("beat_strum_score", score, 16'd2);

        // Two strums two cycles apart: judged twice unless holdoff is built
        idle(4);
        pulses = 0;
        step("dbl_strum_a", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00100, 1'b0);
        pulses += int'(hit) + int'(miss);
        step("dbl_gap", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        pulses += int'(hit) + int'(miss);
        step("dbl_strum_b", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00100, 1'b0);
        pulses += int'(hit) + int'(miss);
`ifdef STRUM_HOLDOFF_EN
        chk("dbl_strum_pulses", pulses, 1);
`else
        chk("dbl_strum_pulses", pulses, 2);
`endif

        // Song end: flush the highway to DONE
        idle(4);
        step("song_end", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
        budget = 20;
        while (m_state != 3 && budget > 0) begin
            step("flush", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
            budget--;
        end
        chk("flush_budget_ok", (budget > 0), 1'b1);
        chk("flush_done", done, 1'b1);
        chk("flush_busy", busy, 1'b0);
        step("start_ignored_beat_in_done", 1'b0, 1'b1, 1'b0, 5'b11111, 5'd0, 1'b0);

        // Fresh game: long streak to exercise the multiplier ramp and cap
        step("restart", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) step("fill2", 1'b0, 1'b1, 1'b0, 5'b00010, 5'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("streak_hit", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00010, 1'b0);
            if (i == 8) begin
                chk("nine_hits_score", score, 16'd10);
                chk("nine_hits_combo", combo, 8'd9);
            end
            step("streak_beat", 1'b0, 1'b1, 1'b0, 5'b00010, 5'd0, 1'b0);
            idle(3);
        end
        chk("forty_hits_score", score, 16'd112);
        chk("forty_hits_combo", combo, 8'd40);

        // Wrong buttons, then strum on an empty hit row
        idle(4);
        saved_score = int'(score);
        step("wrong_strum", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00011, 1'b0);
        chk("wrong_strum_miss", miss, 1'b1);
        chk("wrong_strum_combo", combo, 8'd0);
        chk("wrong_strum_score", score, 16'(saved_score));
        idle(4);
        step("clear_row", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00010, 1'b0);
        idle(4);
        step("empty_strum", 1'b0, 1'b0, 1'b1, 5'd0, 5'b00010, 1'b0);
        chk("empty_strum_miss", miss, 1'b1);
        chk("empty_strum_hit", hit, 1'b0);

        // Asynchronous reset mid-song
        step("pre_reset_beat", 1'b0, 1'b1, 1'b0, 5'b10101, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_state = 0; m_rows = '0; m_score = 0; m_combo = 0; m_hold = 0;
        sbq.push_back(model_snapshot("midsong_reset", 1'b0, 1'b0));
        compare_front();
        #10;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
